// File: rtl/prf_freelist_ctrl_pkg.sv
// Rename-stage sizing shared by the RAT, ROB and PRF free list.
// The free list holds every physical tag that is not an architectural identity mapping.
package prf_freelist_ctrl_pkg;
  localparam int ARF_WIDTH  = 5;
  localparam int PRF_WIDTH  = 6;
  localparam int DECODE_NUM = 4;
  localparam int RETIRE_NUM = 4;
  localparam int DEPTH      = 2**PRF_WIDTH - 2**ARF_WIDTH;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int PTR_W      = IDX_W + 1;
  localparam int DCNT_W     = $clog2(DECODE_NUM + 1);
  localparam int RCNT_W     = $clog2(RETIRE_NUM + 1);

  typedef logic [PRF_WIDTH-1:0] preg_t;
  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [IDX_W-1:0]     idx_t;
endpackage

// File: rtl/prf_freelist_ctrl_popcount_prefix.sv
// Exclusive prefix popcount of a mask plus its total.
// prefix slot i holds the number of set bits below bit i.
module popcount_prefix #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    mask,
  output logic [N*CW-1:0] prefix,
  output logic [CW-1:0]   total
);
  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i*CW +: CW] = acc;
      acc = acc + CW'(mask[i]);
    end
    total = acc;
  end
endmodule

// File: rtl/prf_freelist_ctrl.sv
// Physical-register free list: grants up to DECODE_NUM tags per cycle, reclaims retired tags,
// and restores speculative allocations on flush from the committed head.
module prf_freelist_ctrl
  import prf_freelist_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DECODE_NUM-1:0]            alloc_req,
  output logic                             alloc_ready,
  output logic [DECODE_NUM*PRF_WIDTH-1:0]  alloc_preg,
  input  logic [RETIRE_NUM-1:0]            retire,
  input  logic [RETIRE_NUM-1:0]            rob_areg_v,
  input  logic [RETIRE_NUM*PRF_WIDTH-1:0]  rob_opreg,
  input  logic                             flush,
  output logic [PRF_WIDTH-1:0]             free_count,
  output logic                             overflow_err
);
  preg_t mem [DEPTH];
  ptr_t  head, tail, commit_head;
  ptr_t  avail, occ_next;

  logic [DECODE_NUM*DCNT_W-1:0] alloc_pfx;
  logic [DCNT_W-1:0]            n_alloc;
  logic [RETIRE_NUM-1:0]        rel_mask;
  logic [RETIRE_NUM*RCNT_W-1:0] rel_pfx;
  logic [RCNT_W-1:0]            n_rel;
  idx_t                         rd_idx [DECODE_NUM];
  idx_t                         wr_idx [RETIRE_NUM];

  assign rel_mask = retire & rob_areg_v;

  popcount_prefix #(.N(DECODE_NUM), .CW(DCNT_W)) u_alloc_cnt (
    .mask   (alloc_req),
    .prefix (alloc_pfx),
    .total  (n_alloc)
  );

  popcount_prefix #(.N(RETIRE_NUM), .CW(RCNT_W)) u_rel_cnt (
    .mask   (rel_mask),
    .prefix (rel_pfx),
    .total  (n_rel)
  );

  // Full-width subtraction keeps the wrap bit, so full and empty are distinguishable.
  assign avail       = tail - head;
  assign free_count  = PRF_WIDTH'(avail);
  assign occ_next    = tail + PTR_W'(n_rel) - head;
  assign alloc_ready = (PTR_W'(n_alloc) <= avail) && !flush;

  always_comb begin
    alloc_preg = '0;
    for (int k = 0; k < DECODE_NUM; k++) begin
      rd_idx[k] = head[IDX_W-1:0] + IDX_W'(alloc_pfx[k*DCNT_W +: DCNT_W]);
      if (alloc_req[k] && alloc_ready)
        alloc_preg[k*PRF_WIDTH +: PRF_WIDTH] = mem[rd_idx[k]];
    end
  end

  always_comb begin
    for (int j = 0; j < RETIRE_NUM; j++)
      wr_idx[j] = tail[IDX_W-1:0] + IDX_W'(rel_pfx[j*RCNT_W +: RCNT_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PRF_WIDTH'(DEPTH + i);
      head         <= '0;
      commit_head  <= '0;
      tail         <= PTR_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      for (int j = 0; j < RETIRE_NUM; j++)
        if (rel_mask[j])
          mem[wr_idx[j]] <= rob_opreg[j*PRF_WIDTH +: PRF_WIDTH];
      tail        <= tail + PTR_W'(n_rel);
      commit_head <= commit_head + PTR_W'(n_rel);
      // Flush rewinds past this cycle's releases too, so they are immediately reusable.
      if (flush)
        head <= commit_head + PTR_W'(n_rel);
      else if (alloc_ready)
        head <= head + PTR_W'(n_alloc);
      if (occ_next > PTR_W'(DEPTH))
        overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prf_freelist_ctrl.sv
// Bench for the PRF free list: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_prf_freelist_ctrl;
  import prf_freelist_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  alloc_req = '0;
  logic        alloc_ready;
  logic [23:0] alloc_preg;
  logic [3:0]  retire = '0;
  logic [3:0]  rob_areg_v = '0;
  logic [23:0] rob_opreg = '0;
  logic        flush = 1'b0;
  logic [5:0]  free_count;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  prf_freelist_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_preg   (alloc_preg),
    .retire       (retire),
    .rob_areg_v   (rob_areg_v),
    .rob_opreg    (rob_opreg),
    .flush        (flush),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: unbounded history of tags ever placed on the list, plus
  // integer counts of tags pushed, tags handed out, and tags committed.
  int hist[$];
  int m_tail, m_head, m_commit;
  bit m_ovf, m_tags_ok;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 32; i++) hist.push_back(32 + i);
    m_tail = 32; m_head = 0; m_commit = 0;
    m_ovf = 0; m_tags_ok = 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int na, nr;
    bit rdy;
    if (rst) model_reset();
    else begin
      na  = $countones(alloc_req);
      nr  = $countones(retire & rob_areg_v);
      rdy = (na <= m_tail - m_head) && !flush;
      if (m_tail + nr - m_head > 32) begin
        m_ovf = 1; m_tags_ok = 0;
      end
      for (int j = 0; j < 4; j++)
        if (retire[j] && rob_areg_v[j]) hist.push_back(int'(rob_opreg[j*6 +: 6]));
      m_tail += nr;
      if (flush) m_head = m_commit + nr;
      else if (rdy) m_head += na;
      m_commit += nr;
    end
  end

  always @(negedge clk) begin
    bit          e_rdy;
    logic [23:0] e_preg;
    int          rank;
    if (!rst) begin
      e_rdy  = ($countones(alloc_req) <= m_tail - m_head) && !flush;
      e_preg = '0;
      rank   = 0;
      for (int k = 0; k < 4; k++)
        if (alloc_req[k] && e_rdy) begin
          e_preg[k*6 +: 6] = 6'(hist[m_head + rank]);
          rank++;
        end
      check("model_ready", 32'(alloc_ready), 32'(e_rdy));
      check("model_free", 32'(free_count), 32'((m_tail - m_head) & 63));
      check("model_ovf", 32'(overflow_err), 32'(m_ovf));
      if (m_tags_ok) check("model_preg", 32'(alloc_preg), 32'(e_preg));
    end
  end

  function automatic logic [23:0] pk(input int s3, input int s2, input int s1, input int s0);
    return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = '0; retire = '0; rob_areg_v = '0; rob_opreg = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #10 rst = 1'b0;

    // Reset state and first group
    check("rst_free", 32'(free_count), 32);
    check("rst_ovf", 32'(overflow_err), 0);
    check("rst_preg_idle", 32'(alloc_preg), 0);
    alloc_req = 4'b1111;
    #1;
    check("t1_ready", 32'(alloc_ready), 1);
    check("t1_preg", 32'(alloc_preg), 32'(pk(35, 34, 33, 32)));
    step();
    check("t1_free", 32'(free_count), 28);

    // Sparse group packs grants in slot order
    alloc_req = 4'b1010;
    #1;
    check("t2_preg", 32'(alloc_preg), 32'(pk(37, 0, 36, 0)));
    step();
    check("t2_free", 32'(free_count), 26);

    // Drain to empty, then a single request must stall
    do_reset();
    alloc_req = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    check("t3_empty", 32'(free_count), 0);
    alloc_req = 4'b0001;
    #1;
    check("t3_stall_ready", 32'(alloc_ready), 0);
    check("t3_stall_preg", 32'(alloc_preg), 0);
    step();
    check("t3_stall_free", 32'(free_count), 0);

    // Release with holes while empty; release is not bypassed to allocation
    retire = 4'b1111; rob_areg_v = 4'b0101; rob_opreg = pk(0, 9, 0, 5);
    alloc_req = 4'b0011;
    #1;
    check("t4_nobypass", 32'(alloc_ready), 0);
    step();
    idle();
    check("t4_free", 32'(free_count), 2);
    alloc_req = 4'b0011;
    #1;
    check("t4_ready", 32'(alloc_ready), 1);
    check("t4_preg", 32'(alloc_preg), 32'(pk(0, 0, 9, 5)));
    step();
    check("t4_free_after", 32'(free_count), 0);

    // Three free, four requested: no partial grant
    idle();
    retire = 4'b0111; rob_areg_v = 4'b0111; rob_opreg = pk(0, 12, 11, 10);
    step();
    idle();
    check("t3_free3", 32'(free_count), 3);
    alloc_req = 4'b1111;
    #1;
    check("t3_partial_ready", 32'(alloc_ready), 0);
    check("t3_partial_preg", 32'(alloc_preg), 0);
    step();
    check("t3_partial_free", 32'(free_count), 3);

    // Flush together with releases
    do_reset();
    alloc_req = 4'b1111;
    step();
    step();
    retire = 4'b0011; rob_areg_v = 4'b0011; rob_opreg = pk(0, 0, 2, 1); flush = 1'b1;
    #1;
    check("t5_flush_ready", 32'(alloc_ready), 0);
    step();
    idle();
    check("t5_free", 32'(free_count), 32);
    alloc_req = 4'b1111;
    #1;
    check("t5_preg", 32'(alloc_preg), 32'(pk(37, 36, 35, 34)));
    step();

    // Asynchronous reset mid-cycle during alloc and release
    retire = 4'b0001; rob_areg_v = 4'b0001; rob_opreg = pk(0, 0, 0, 7);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_free", 32'(free_count), 32);
    check("t6_async_ovf", 32'(overflow_err), 0);
    check("t6_async_preg", 32'(alloc_preg), 32'(pk(35, 34, 33, 32)));
    idle();
    rst = 1'b0;

    // Release into a full list sets the sticky error
    step();
    retire = 4'b0001; rob_areg_v = 4'b0001; rob_opreg = pk(0, 0, 0, 7);
    step();
    idle();
    check("t6_ovf_set", 32'(overflow_err), 1);
    step();
    step();
    check("t6_ovf_sticky", 32'(overflow_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prf_freelist_ctrl.md
Name: prf_freelist_ctrl

Overview:
Physical-register free-list manager for the 4-wide rename stage. It hands out free PRF tags to up to DECODE_NUM destination-writing instructions per cycle and reclaims old PRF tags from up to RETIRE_NUM retiring ROB entries per cycle. It keeps a committed head pointer so a pipeline flush returns every speculatively allocated tag in one cycle. It sits between decode/RAT and the ROB retire port.

Parameters:
ARF_WIDTH, 5, architectural register index width (32 ARF).
PRF_WIDTH, 6, physical register index width (64 PRF).
DECODE_NUM, 4, allocation slots per cycle.
RETIRE_NUM, 4, release slots per cycle.
DEPTH, 2**PRF_WIDTH - 2**ARF_WIDTH (32), free-list capacity (derived).

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  reset, asynchronous, active-high.
alloc_req  in  DECODE_NUM  per-slot request; slot k has a valid rd (decoder guarantees rd!=0).
alloc_ready  out  1  whole group granted this cycle.
alloc_preg  out  DECODE_NUM*PRF_WIDTH  slot k tag at [k*PRF_WIDTH +: PRF_WIDTH].
retire  in  RETIRE_NUM  ROB oldest entries retiring.
rob_areg_v  in  RETIRE_NUM  retiring entry has a destination.
rob_opreg  in  RETIRE_NUM*PRF_WIDTH  old PRF tag per retiring entry, same packing.
flush  in  1  squash all speculative allocations.
free_count  out  PRF_WIDTH  number of tags currently free.
overflow_err  out  1  sticky error flag.

Behaviour:
- Storage: circular array mem[DEPTH] of PRF tags. Pointers head, tail and commit_head are each log2(DEPTH)+1 bits, with the MSB as the wrap bit. free_count = tail - head.
- Reset (async, any time): mem[i]=DEPTH+i (P32..P63), head=0, commit_head=0, tail=DEPTH (full), overflow_err=0. P0..P31 are the identity ARF mappings held by the RAT.
- Reset output values: free_count=32, alloc_ready=1 while alloc_req is within capacity, alloc_preg=0 when alloc_req=0, overflow_err=0.
- n_alloc = popcount(alloc_req).
- alloc_ready = (n_alloc <= free_count) && !flush. This is combinational, zero latency.
- alloc_preg slot k = mem[(head + popcount(alloc_req[k-1:0])) mod DEPTH] when alloc_req[k] && alloc_ready, else 0. Grants are packed in slot order.
- Groups are all-or-nothing: no partial grant. On stall, head is unchanged and the requester holds alloc_req.
- On posedge with alloc_ready, head += n_alloc.
- n_rel = popcount(retire & rob_areg_v).
- Released tags are compacted in slot order and written to mem[tail..tail+n_rel-1] mod DEPTH. Then tail += n_rel and commit_head += n_rel.
- Releases written this cycle are not visible to allocation until the next cycle (no bypass). Simultaneous alloc and release is legal.
- Flush: head <= commit_head + n_rel, which includes this cycle's releases. Releases are still processed, and no allocation happens that cycle.
- Wrap-around: all mem indices use the pointer modulo DEPTH. Pointer compare uses the full width including the wrap bit.
- overflow_err is set and sticky when (tail + n_rel) - head > DEPTH. When it fires, the write is still performed and the tail still advances; the error is for verification.
- Tag 0 is never released by a legal ROB. The block does not check for it.

Decomposition:
- Shared rename package holds ARF_WIDTH, PRF_WIDTH, DECODE_NUM, RETIRE_NUM and the DEPTH derivation. These are shared with the rename unit and the ROB.
- One sub-module, popcount_prefix: for an N-bit mask it outputs per-bit prefix counts and the total. It is instantiated once for alloc_req and once for retire & rob_areg_v.

Test Plan:
1. Reset, then alloc_req=1111 -> alloc_ready=1, tags P32,P33,P34,P35; next cycle free_count=28.
2. Then alloc_req=1010 -> slot1=P36, slot3=P37, slots 0 and 2 = 0; next free_count=26.
3. From reset, 8 cycles of 1111 -> free_count=0. Then alloc_req=0001 -> alloc_ready=0, head and free_count unchanged. With free_count=3, alloc_req=1111 -> stall, no partial grant.
4. At free_count=0: retire=1111, rob_areg_v=0101, opregs {P9@slot2, P5@slot0} plus alloc_req=0011 the same cycle -> alloc stalled; next cycle free_count=2, and alloc 0011 gives P5,P9.
5. Reset, alloc 1111 twice, then retire=0011, areg_v=0011, opregs P1,P2 together with flush -> alloc_ready=0. Next cycle free_count=32, and alloc 1111 gives P34,P35,P36,P37.
6. Assert rst asynchronously mid-cycle during alloc and release -> state immediately returns to reset values (free_count=32, overflow_err=0). Extra: from reset, retire 1 with areg_v -> overflow_err=1 and stays set.
